// File: rtl/nibble_stream_packer.sv
// nibble_stream_packer
// Packs NUM consecutive W-bit chunks, received over a valid/ready handshake,
// into one W*NUM-bit word held in a registered valid/ready output stage.
// A flush request emits the current partial word, zero-padded, together
// with any chunk accepted in the same cycle. Empty words are never emitted.
module nibble_stream_packer #(
    parameter int unsigned W         = 4,
    parameter int unsigned NUM       = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [W*NUM-1:0]           out_data,
    output logic [$clog2(NUM+1)-1:0]   out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned CW = $clog2(NUM + 1);
    localparam int unsigned DW = W * NUM;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);

    // Accumulator and fill counter for the word being assembled
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Output register
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_valid_q, out_valid_d;

    // Handshake / control terms
    logic          slot_free;
    logic          last_chunk;
    logic          in_ready_w;
    logic          accept;
    logic          flush_fire;
    logic          load;
    logic [DW-1:0] chunk_word;
    logic [DW-1:0] merged;

    // Handshake decode: only the final chunk of a word waits for the output slot
    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        last_chunk = (cnt_q == LAST_IDX);
        in_ready_w = !last_chunk || slot_free;
        accept     = in_valid && in_ready_w;
        flush_fire = flush && slot_free && ((cnt_q != '0) || accept);
        load       = (accept && last_chunk) || flush_fire;
    end

    // Place the incoming chunk at the position selected by the fill counter
    always_comb begin
        chunk_word = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (cnt_q == CW'(k)) begin
                if (MSB_FIRST) begin
                    chunk_word[W*(NUM-1-k) +: W] = in_data;
                end else begin
                    chunk_word[W*k +: W] = in_data;
                end
            end
        end
        merged = acc_q | (accept ? chunk_word : '0);
    end

    // Next-state: load a full or flushed word, otherwise accumulate and drain
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (load) begin
            // A load always coincides with a free slot, so it may overwrite
            // a word being consumed this same cycle (back-to-back output).
            out_data_d  = merged;
            out_count_d = cnt_q + CW'(accept);
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
        end else begin
            if (accept) begin
                acc_d = merged;
                cnt_d = cnt_q + CW'(1);
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous, dominant reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_w;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_stream_packer.sv
// Scoreboard bench for nibble_stream_packer: three instances
//   u0: W=4 NUM=2 MSB_FIRST=1, u1: W=4 NUM=3 MSB_FIRST=0, u2: W=4 NUM=3 MSB_FIRST=1.
// Expected words are queued by the stimulus; per-instance monitors pop and
// compare whenever a word is handed over (out_valid && out_ready).
module tb_nibble_stream_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // u0 signals
    logic [3:0]  in_data0 = '0;
    logic        in_valid0 = 1'b0, flush0 = 1'b0, out_ready0 = 1'b1;
    logic        in_ready0, out_valid0;
    logic [7:0]  out_data0;
    logic [1:0]  out_count0;
    // u1 signals
    logic [3:0]  in_data1 = '0;
    logic        in_valid1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b1;
    logic        in_ready1, out_valid1;
    logic [11:0] out_data1;
    logic [1:0]  out_count1;
    // u2 signals
    logic [3:0]  in_data2 = '0;
    logic        in_valid2 = 1'b0, flush2 = 1'b0, out_ready2 = 1'b1;
    logic        in_ready2, out_valid2;
    logic [11:0] out_data2;
    logic [1:0]  out_count2;

    nibble_stream_packer #(.W(4), .NUM(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .flush(flush0), .out_data(out_data0),
        .out_count(out_count0), .out_valid(out_valid0), .out_ready(out_ready0));

    nibble_stream_packer #(.W(4), .NUM(3), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .flush(flush1), .out_data(out_data1),
        .out_count(out_count1), .out_valid(out_valid1), .out_ready(out_ready1));

    nibble_stream_packer #(.W(4), .NUM(3), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .flush(flush2), .out_data(out_data2),
        .out_count(out_count2), .out_valid(out_valid2), .out_ready(out_ready2));

    logic [15:0] exp_d0[$], exp_d1[$], exp_d2[$];
    logic [3:0]  exp_c0[$], exp_c1[$], exp_c2[$];

    bit chk_gap0 = 1'b0;
    bit have_prev0 = 1'b0;
    int prev_cyc0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_word(input int id, input logic [15:0] d, input logic [3:0] c);
        case (id)
            0: begin exp_d0.push_back(d); exp_c0.push_back(c); end
            1: begin exp_d1.push_back(d); exp_c1.push_back(c); end
            default: begin exp_d2.push_back(d); exp_c2.push_back(c); end
        endcase
    endtask

    // Monitor for u0, including inter-word spacing during the streaming phase
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready0) begin
            if (exp_d0.size() == 0) begin
                check("u0 unexpected word", {24'd0, out_data0}, 32'hFFFF_FFFF);
            end else begin
                check("u0 data", {24'd0, out_data0}, {16'd0, exp_d0.pop_front()});
                check("u0 count", {30'd0, out_count0}, {28'd0, exp_c0.pop_front()});
            end
            if (chk_gap0 && have_prev0)
                check("u0 stream spacing", cyc - prev_cyc0, 2);
            have_prev0 = 1'b1;
            prev_cyc0  = cyc;
        end
    end

    // Monitor for u1
    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (exp_d1.size() == 0) begin
                check("u1 unexpected word", {20'd0, out_data1}, 32'hFFFF_FFFF);
            end else begin
                check("u1 data", {20'd0, out_data1}, {16'd0, exp_d1.pop_front()});
                check("u1 count", {30'd0, out_count1}, {28'd0, exp_c1.pop_front()});
            end
        end
    end

    // Monitor for u2
    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (exp_d2.size() == 0) begin
                check("u2 unexpected word", {20'd0, out_data2}, 32'hFFFF_FFFF);
            end else begin
                check("u2 data", {20'd0, out_data2}, {16'd0, exp_d2.pop_front()});
                check("u2 count", {30'd0, out_count2}, {28'd0, exp_c2.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one chunk (optionally with flush) and hold until accepted, bounded
    task automatic send(input int id, input logic [3:0] d, input bit fl);
        bit acc;
        acc = 1'b0;
        case (id)
            0: begin in_data0 = d; in_valid0 = 1'b1; flush0 = fl; end
            1: begin in_data1 = d; in_valid1 = 1'b1; flush1 = fl; end
            default: begin in_data2 = d; in_valid2 = 1'b1; flush2 = fl; end
        endcase
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            case (id)
                0: acc = in_ready0;
                1: acc = in_ready1;
                default: acc = in_ready2;
            endcase
            tick();
        end
        if (!acc) check("send timeout", 32'd0, 32'd1);
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    endtask

    task automatic pulse_flush(input int id);
        case (id)
            0: flush0 = 1'b1;
            1: flush1 = 1'b1;
            default: flush2 = 1'b1;
        endcase
        tick();
        flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("reset out_valid0", {31'd0, out_valid0}, 32'd0);
        check("reset out_data0", {24'd0, out_data0}, 32'd0);
        check("reset out_count1", {30'd0, out_count1}, 32'd0);
        check("reset in_ready2", {31'd0, in_ready2}, 32'd0 + 1);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Basic pair, MSB first
        expect_word(0, 16'h00A5, 4'd2);
        send(0, 4'hA, 1'b0);
        send(0, 4'h5, 1'b0);
        tick(); tick();
        @(negedge clk);
        check("u0 valid drops after one word", {31'd0, out_valid0}, 32'd0);
        tick();

        // LSB-first three-chunk word
        expect_word(1, 16'h0321, 4'd3);
        send(1, 4'h1, 1'b0);
        send(1, 4'h2, 1'b0);
        send(1, 4'h3, 1'b0);
        tick();

        // LSB-first partial flush of two chunks
        expect_word(1, 16'h0065, 4'd2);
        send(1, 4'h5, 1'b0);
        send(1, 4'h6, 1'b0);
        pulse_flush(1);
        tick();

        // MSB-first three-chunk word
        expect_word(2, 16'h0123, 4'd3);
        send(2, 4'h1, 1'b0);
        send(2, 4'h2, 1'b0);
        send(2, 4'h3, 1'b0);
        tick();

        // Flush with a single buffered chunk, then a flush with nothing buffered
        expect_word(0, 16'h00C0, 4'd1);
        send(0, 4'hC, 1'b0);
        pulse_flush(0);
        tick();
        pulse_flush(0);
        tick();
        @(negedge clk);
        check("u0 empty flush emits nothing", {31'd0, out_valid0}, 32'd0);
        tick();

        // Flush in the same cycle as accepting the first chunk
        expect_word(2, 16'h0700, 4'd1);
        send(2, 4'h7, 1'b1);
        tick();

        // Backpressure
        out_ready0 = 1'b0;
        expect_word(0, 16'h00A5, 4'd2);
        expect_word(0, 16'h0034, 4'd2);
        send(0, 4'hA, 1'b0);
        send(0, 4'h5, 1'b0);
        send(0, 4'h3, 1'b0);
        in_data0 = 4'h4; in_valid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp in_ready low", {31'd0, in_ready0}, 32'd0);
            check("bp data held", {24'd0, out_data0}, 32'hA5);
            check("bp valid held", {31'd0, out_valid0}, 32'd1);
            tick();
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        check("bp in_ready on release", {31'd0, in_ready0}, 32'd1);
        tick();
        in_valid0 = 1'b0;
        @(negedge clk);
        check("bp back-to-back valid", {31'd0, out_valid0}, 32'd1);
        tick(); tick();

        // Continuous stream 0x0..0xF
        for (int i = 0; i < 16; i += 2)
            expect_word(0, 16'((i << 4) | (i + 1)), 4'd2);
        have_prev0 = 1'b0;
        chk_gap0   = 1'b1;
        for (int i = 0; i < 16; i++)
            send(0, 4'(i), 1'b0);
        tick(); tick();
        chk_gap0 = 1'b0;

        // Reset mid-word
        send(0, 4'h9, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst out_data0", {24'd0, out_data0}, 32'd0);
        check("rst out_count0", {30'd0, out_count0}, 32'd0);
        check("rst out_valid0", {31'd0, out_valid0}, 32'd0);
        tick();
        rst = 1'b0;
        expect_word(0, 16'h0012, 4'd2);
        send(0, 4'h1, 1'b0);
        send(0, 4'h2, 1'b0);
        tick(); tick(); tick();

        // All expected words observed
        check("u0 queue drained", exp_d0.size(), 32'd0);
        check("u1 queue drained", exp_d1.size(), 32'd0);
        check("u2 queue drained", exp_d2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_stream_packer.md
# nibble_stream_packer

Sequential, parametrised concatenation unit. Accepts W-bit chunks one per cycle over a valid/ready handshake and packs NUM consecutive chunks into one W*NUM-bit word. The packed word is presented on a registered valid/ready output. A flush request emits a partially filled, zero-padded word. The block sits between narrow data sources (switch/nibble producers) and wide consumers (display and register logic), replacing fixed combinational {A,B} concatenation where operands arrive over time.

## Interface
- W, default 4: chunk width in bits (≥1).
- NUM, default 2: chunks per packed word (≥2).
- MSB_FIRST, default 1: 1 places the first chunk in the most-significant position; 0 places it in the least-significant position.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  chunk payload.
- in_valid  input  1  chunk offered.
- in_ready  output  1  chunk accepted this cycle when in_valid && in_ready (combinational).
- flush  input  1  level request to emit the current partial word.
- out_data  output  W*NUM  packed word (registered).
- out_count  output  clog2(NUM+1)  number of valid chunks in out_data; equals NUM for a full word.
- out_valid  output  1  out_data/out_count hold a word.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.

## Operation
- Internal state: accumulator acc[W*NUM], fill counter cnt (0..NUM-1), output register {out_data, out_count, out_valid}.
- Chunk placement, with k = 0-based arrival index within the word:
  - MSB_FIRST=1: bits [W*(NUM-k)-1 : W*(NUM-k-1)].
  - MSB_FIRST=0: bits [W*(k+1)-1 : W*k].
  - Unfilled positions are always 0.
- Output slot free: !out_valid || out_ready.
- in_ready = (cnt != NUM-1) || slot free. A non-final chunk is never stalled.
- Accept (in_valid && in_ready), non-final, no flush: write chunk at index cnt; cnt++.
- Accept of the final chunk (cnt == NUM-1): the full word (acc plus chunk) loads the output register; out_count = NUM; out_valid = 1; acc cleared; cnt = 0.
- Flush: honoured when slot free and (cnt > 0 or accept this cycle).
  - Emits acc plus any same-cycle accepted chunk.
  - out_count = cnt + (accept ? 1 : 0).
  - acc cleared; cnt = 0.
  - A flush with cnt == 0 and no accept is a no-op: no empty words are ever emitted.
  - A flush that is not honoured (slot busy) has no effect; the requester holds flush.
- Output consumed (out_valid && out_ready) with no new load: out_valid = 0. out_data and out_count keep their last values.
- Load and consume in the same cycle: the new word replaces the old one; out_valid stays 1, giving back-to-back throughput.
- out_data is stable while out_valid && !out_ready.

## Timing
- Reset, synchronous and dominant over all other inputs: acc = 0, cnt = 0, out_data = 0, out_count = 0, out_valid = 0. After reset, in_ready = 1.
- Reset mid-word discards the partial chunks; reset while out_valid drops the pending word.
- Latency: out_valid rises on the clock edge that accepts the final chunk, or that honours a flush. The word is visible the following cycle.
- Throughput: one chunk per cycle sustained while out_ready = 1. This gives one word every NUM cycles.
- Backpressure: with out_valid = 1 and out_ready = 0, chunks 0..NUM-2 of the next word are still accepted. The final chunk is stalled (in_ready = 0) until the slot frees.
- in_ready depends combinationally on out_ready; no other combinational input-to-output paths exist.

## Test plan
- Defaults (W=4, NUM=2, MSB_FIRST=1), out_ready = 1: send 0xA then 0x5 on consecutive cycles -> one cycle later out_data = 0xA5, out_count = 2, out_valid high for exactly 1 cycle.
- MSB_FIRST=0, W=4, NUM=3: send 0x1, 0x2, 0x3 -> out_data = 0x321, out_count = 3.
- Flush: send 0xC only, then assert flush -> out_data = 0xC0, out_count = 1. A repeated flush with cnt = 0 emits nothing. Flush asserted in the same cycle as accepting 0x7 (cnt = 0, NUM = 3, W = 4) -> out_data = 0x700, out_count = 1.
- Backpressure: hold out_ready = 0 after word 0xA5 is produced; offer 0x3, 0x4 -> 0x3 accepted, in_ready = 0 while 0x4 is offered, out_data stays 0xA5. Raise out_ready -> 0x4 accepted in that cycle; next cycle out_data = 0x34, out_valid = 1, with no gap.
- Continuous stream 0x0..0xF with out_ready = 1 -> words 0x01, 0x23, …, 0xEF, one every 2 cycles, none dropped or duplicated.
- Reset after one chunk (0x9), then send 0x1, 0x2 -> out_data = 0x12. During the reset cycle all outputs are 0 and out_valid = 0.
